// File: rtl/timer_irq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : timer_irq_pkg                                          |
// | Description : Shared register offsets, pending-bit indices and the   |
// |               interrupt handshake state encoding for timer_irq_ctrl. |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package timer_irq_pkg;

  // Register window offsets
  localparam logic [7:0] IER_ADDR  = 8'h00;
  localparam logic [7:0] ISR_ADDR  = 8'h01;
  localparam logic [7:0] ECNT_ADDR = 8'h02;
  localparam logic [7:0] STAT_ADDR = 8'h03;

  // Pending / enable bit positions (OVF has ack priority over UDF)
  localparam int OVF_BIT = 0;
  localparam int UDF_BIT = 1;

  // Interrupt handshake states, visible in STAT[1:0]
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ASSERT = 2'b01,
    ACKED  = 2'b10
  } irq_state_e;

endpackage
`default_nettype wire

// File: rtl/timer_irq_apb_regs.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : timer_irq_apb_regs                                     |
// | Description : APB register window: IER/ISR/ECNT storage, event       |
// |               capture, W1C handling and unmapped-offset errors.      |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module timer_irq_apb_regs import timer_irq_pkg::*; #(
  parameter int CNT_W  = 8,
  parameter int ADDR_W = 8
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [7:0]        pwdata,
  output logic [7:0]        prdata,
  output logic              pready,
  output logic              pslverr,
  input  logic              ovf_evt,
  input  logic              udf_evt,
  input  logic [1:0]        ack_clr,
  input  logic [2:0]        stat,
  output logic [1:0]        ier,
  output logic [1:0]        isr
);

  logic [1:0]       r_ier;
  logic [1:0]       r_isr;
  logic [CNT_W-1:0] r_ecnt;

  logic             w_access;
  logic             w_valid;
  logic             w_wr;
  logic             w_wr_ier;
  logic             w_wr_isr;
  logic             w_wr_ecnt;
  logic [1:0]       w_set;
  logic [1:0]       w_w1c;
  logic [1:0]       w_inc;
  logic [CNT_W:0]   w_sum;
  logic             w_unused;

  assign w_access  = psel & penable;
  assign w_valid   = (paddr <= ADDR_W'(STAT_ADDR));
  assign w_wr      = w_access & pwrite & w_valid;
  assign w_wr_ier  = w_wr & (paddr == ADDR_W'(IER_ADDR));
  assign w_wr_isr  = w_wr & (paddr == ADDR_W'(ISR_ADDR));
  assign w_wr_ecnt = w_wr & (paddr == ADDR_W'(ECNT_ADDR));

  assign w_set = {udf_evt, ovf_evt};
  assign w_w1c = w_wr_isr ? pwdata[1:0] : 2'b00;
  assign w_inc = {1'b0, ovf_evt} + {1'b0, udf_evt};
  assign w_sum = {1'b0, r_ecnt} + (CNT_W+1)'(w_inc);

  assign w_unused = ^pwdata[7:2];

  // Register updates: event sets override any clear landing in the same cycle
  always_ff @(posedge pclk) begin
    if (preset) begin
      r_ier  <= 2'b00;
      r_isr  <= 2'b00;
      r_ecnt <= '0;
    end else begin
      if (w_wr_ier) begin
        r_ier <= pwdata[1:0];
      end
      r_isr <= (r_isr & ~w_w1c & ~ack_clr) | w_set;
      if (w_wr_ecnt) begin
        r_ecnt <= CNT_W'(w_inc);
      end else if (w_sum[CNT_W]) begin
        r_ecnt <= {CNT_W{1'b1}};
      end else begin
        r_ecnt <= w_sum[CNT_W-1:0];
      end
    end
  end

  // Read mux: only driven during a mapped access phase outside reset
  always_comb begin
    prdata = 8'h00;
    if (w_access && !preset) begin
      case (paddr)
        ADDR_W'(IER_ADDR):  prdata = {6'b0, r_ier};
        ADDR_W'(ISR_ADDR):  prdata = {6'b0, r_isr};
        ADDR_W'(ECNT_ADDR): prdata = 8'(r_ecnt);
        ADDR_W'(STAT_ADDR): prdata = {5'b0, stat};
        default:            prdata = 8'h00;
      endcase
    end
  end

  assign pready  = 1'b1;
  assign pslverr = w_access & ~w_valid & ~preset;
  assign ier     = r_ier;
  assign isr     = r_isr;

endmodule
`default_nettype wire

// File: rtl/timer_irq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : timer_irq_ctrl                                         |
// | Description : Timer interrupt stage: sticky OVF/UDF pending bits,    |
// |               masked level IRQ with ack handshake and deassert gap.  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module timer_irq_ctrl import timer_irq_pkg::*; #(
  parameter int CNT_W  = 8,
  parameter int ADDR_W = 8
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [7:0]        pwdata,
  output logic [7:0]        prdata,
  output logic              pready,
  output logic              pslverr,
  input  logic              ovf_evt,
  input  logic              udf_evt,
  input  logic              irq_ack,
  output logic              irq_o
);

  irq_state_e r_state;
  irq_state_e w_state_nxt;
  logic       r_irq;
  logic [1:0] w_ier;
  logic [1:0] w_isr;
  logic [1:0] w_pend;
  logic [1:0] w_ack_clr;
  logic [2:0] w_stat;

  assign w_pend = w_isr & w_ier;
  assign w_stat = {r_irq, r_state};

  timer_irq_apb_regs #(
    .CNT_W  (CNT_W),
    .ADDR_W (ADDR_W)
  ) u_regs (
    .pclk    (pclk),
    .preset  (preset),
    .psel    (psel),
    .penable (penable),
    .pwrite  (pwrite),
    .paddr   (paddr),
    .pwdata  (pwdata),
    .prdata  (prdata),
    .pready  (pready),
    .pslverr (pslverr),
    .ovf_evt (ovf_evt),
    .udf_evt (udf_evt),
    .ack_clr (w_ack_clr),
    .stat    (w_stat),
    .ier     (w_ier),
    .isr     (w_isr)
  );

  // Next state and ack arbitration (OVF wins over UDF among enabled bits)
  always_comb begin
    w_state_nxt = r_state;
    w_ack_clr   = 2'b00;
    case (r_state)
      IDLE: begin
        if (|w_pend) w_state_nxt = ASSERT;
      end
      ASSERT: begin
        if (irq_ack) begin
          w_state_nxt = ACKED;
          if (w_pend[OVF_BIT])      w_ack_clr[OVF_BIT] = 1'b1;
          else if (w_pend[UDF_BIT]) w_ack_clr[UDF_BIT] = 1'b1;
        end else if (w_pend == 2'b00) begin
          w_state_nxt = IDLE;
        end
      end
      ACKED: begin
        w_state_nxt = (|w_pend) ? ASSERT : IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register with a registered IRQ level tracking ASSERT
  always_ff @(posedge pclk) begin
    if (preset) begin
      r_state <= IDLE;
      r_irq   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_irq   <= (w_state_nxt == ASSERT);
    end
  end

  assign irq_o = r_irq;

endmodule
`default_nettype wire
